dcm_lock_supervisor: RTL

DCM_LOCK_SUPERVISOR -- requirements
Module: dcm_lock_supervisor

---
 rtl/dcm_lock_supervisor_pkg.sv | 29 ++
 rtl/dcm_lock_supervisor_sync.sv | 27 ++
 rtl/dcm_lock_supervisor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dcm_lock_supervisor_pkg.sv
// Shared clock-management definitions for the DCM lock supervisor.
// Contents:
//   sup_state_t           - supervisor FSM state encoding (visible on state_o)
//   STATUS_CLKFX_STOPPED  - bit of the DCM STATUS bus that flags CLKFX stopped
//   TIMER_WIDTH           - width of the shared phase timer (covers every limit)
//   sat_inc4 / sat_inc16  - saturating increment helpers for the counters
package dcm_lock_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET      = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_STABLE_CHK = 3'd3,
        ST_LOCKED     = 3'd4,
        ST_FAIL       = 3'd5
    } sup_state_t;

    localparam int STATUS_CLKFX_STOPPED = 2;
    localparam int TIMER_WIDTH          = 24;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/dcm_lock_supervisor_sync.sv
// Two-flop synchronizer for a single level signal crossing into clk.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears both flops
//   din   - asynchronous input level
//   dout  - synchronized level, two clk edges behind din
module bit_synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/dcm_lock_supervisor.sv
// DCM lock supervisor: pulses the DCM reset, waits for LOCKED with a timeout,
// qualifies the lock over a run of consecutive good cycles, and retries on
// timeout until an optional retry limit is exhausted.
// Ports:
//   clk_i           - single clock, all logic on its rising edge
//   reset_i         - synchronous active-high reset
//   enable_i        - supervisor run enable; low parks the FSM in IDLE
//   dcm_locked_i    - raw DCM LOCKED (asynchronous)
//   dcm_status_i    - raw DCM STATUS (asynchronous), bit 2 = CLKFX stopped
//   clksel_change_i - one-cycle pulse on a clock-source change, forces relock
//   retry_limit_i   - max consecutive timeouts, 0 = unlimited
//   dcm_rst_o       - registered DCM reset request
//   locked_o        - qualified stable lock
//   fail_o          - retry limit exhausted
//   state_o         - current FSM state encoding
//   retry_count_o   - consecutive timeouts since last lock (saturates at 15)
//   lost_count_o    - lock losses while LOCKED (saturates at 0xFFFF)
module dcm_lock_supervisor
    import dcm_lock_supervisor_pkg::*;
#(
    parameter int RST_CYCLES    = 4,
    parameter int STABLE_CYCLES = 255,
    parameter int LOCK_TIMEOUT  = 65535
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        dcm_locked_i,
    input  logic [7:0]  dcm_status_i,
    input  logic        clksel_change_i,
    input  logic [3:0]  retry_limit_i,
    output logic        dcm_rst_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic [2:0]  state_o,
    output logic [3:0]  retry_count_o,
    output logic [15:0] lost_count_o
);

    localparam logic [TIMER_WIDTH-1:0] RST_LAST     = TIMER_WIDTH'(RST_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] STABLE_LAST  = TIMER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(LOCK_TIMEOUT - 1);

    sup_state_t             state, next_state;
    logic [TIMER_WIDTH-1:0] timer, next_timer;
    logic [3:0]             retry_count, next_retry, retry_inc;
    logic [15:0]            lost_count, next_lost;
    logic                   locked_s, fxstop_s, good;
    logic                   status_unused;

    // Only the CLKFX-stopped bit of STATUS matters; the rest is deliberately dropped.
    assign status_unused = ^(dcm_status_i & ~(8'd1 << STATUS_CLKFX_STOPPED));

    bit_synchronizer u_sync_locked (
        .clk   (clk_i),
        .reset (reset_i),
        .din   (dcm_locked_i),
        .dout  (locked_s)
    );

    bit_synchronizer u_sync_fxstop (
        .clk   (clk_i),
        .reset (reset_i),
        .din   (dcm_status_i[STATUS_CLKFX_STOPPED]),
        .dout  (fxstop_s)
    );

    // The DCM is only trusted while it reports lock and CLKFX is running.
    assign good = locked_s & ~fxstop_s;

    // Next-state logic. Disable beats a clock-source change, which beats the
    // per-state rules. One shared timer serves RESET length, lock timeout and
    // stability run; it restarts from zero on every state change.
    always_comb begin
        next_state = state;
        next_timer = '0;
        next_retry = retry_count;
        next_lost  = lost_count;
        retry_inc  = sat_inc4(retry_count);

        if (!enable_i) begin
            next_state = ST_IDLE;
            next_retry = '0;
        end else if (clksel_change_i && state != ST_IDLE) begin
            next_state = ST_RESET;
            next_retry = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_RESET;
                end
                ST_RESET: begin
                    if (timer == RST_LAST) begin
                        next_state = ST_WAIT_LOCK;
                    end else begin
                        next_timer = timer + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (good) begin
                        next_state = ST_STABLE_CHK;
                    end else if (timer == TIMEOUT_LAST) begin
                        next_retry = retry_inc;
                        if (retry_limit_i != 4'd0 && retry_inc == retry_limit_i) begin
                            next_state = ST_FAIL;
                        end else begin
                            next_state = ST_RESET;
                        end
                    end else begin
                        next_timer = timer + 1'b1;
                    end
                end
                ST_STABLE_CHK: begin
                    if (!good) begin
                        next_state = ST_WAIT_LOCK;
                    end else if (timer == STABLE_LAST) begin
                        next_state = ST_LOCKED;
                        next_retry = '0;
                    end else begin
                        next_timer = timer + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!good) begin
                        next_state = ST_RESET;
                        next_lost  = sat_inc16(lost_count);
                    end
                end
                ST_FAIL: begin
                    next_state = ST_FAIL;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end

        if (next_state != state) begin
            next_timer = '0;
        end
    end

    // State, counters and outputs all update together; the flag outputs are
    // decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            timer       <= '0;
            retry_count <= '0;
            lost_count  <= '0;
            dcm_rst_o   <= 1'b1;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            retry_count <= next_retry;
            lost_count  <= next_lost;
            dcm_rst_o   <= (next_state == ST_IDLE) || (next_state == ST_RESET);
            locked_o    <= (next_state == ST_LOCKED);
            fail_o      <= (next_state == ST_FAIL);
        end
    end

    assign state_o       = state;
    assign retry_count_o = retry_count;
    assign lost_count_o  = lost_count;

endmodule
